amiga_clk_ctrl: RTL and testbench

AMIGA_CLK_CTRL -- requirements
Module: amiga_clk_ctrl

---
 rtl/amiga_clk_ctrl_pkg.sv | 25 ++
 rtl/amiga_clk_ctrl_sync_bit.sv | 25 ++
 rtl/amiga_clk_ctrl.sv | 143 ++++++++++++++
 tb/tb_amiga_clk_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/amiga_clk_ctrl_pkg.sv
// Shared types and constants for the Amiga clock/reset controller.
// Holds the lock FSM state encoding and the phase/E-clock divider sizes.
package amiga_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } clk_state_e;

  localparam int PHASE_W  = 5;
  localparam int ECLK_DIV = 10;

  // Next E-counter value, wrapping after ECLK_DIV steps.
  function automatic logic [3:0] ecnt_step(input logic [3:0] cnt);
    logic [3:0] res;
    if (cnt == 4'(ECLK_DIV - 1)) begin
      res = 4'd0;
    end else begin
      res = cnt + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/amiga_clk_ctrl_sync_bit.sv
// Multi-flop synchronizer bringing the asynchronous PLL lock flag into clk.
// The last stage is the only one downstream logic may look at.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/amiga_clk_ctrl.sv
// Clock/reset controller for the Amiga core: waits for a stable PLL lock,
// then releases core reset and generates the 28/7/colour/E-clock enables.
module amiga_clk_ctrl
  import amiga_clk_ctrl_pkg::*;
#(
  parameter int LOCK_WAIT   = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  output logic               core_reset,
  output logic               ready,
  output logic               clk28_en,
  output logic               clk7_en,
  output logic               clk7n_en,
  output logic               cck,
  output logic               eclk_en,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [15:0]        WAIT_LAST = 16'(LOCK_WAIT - 1);
  localparam logic [3:0]         ECNT_LAST = 4'(ECLK_DIV - 1);
  localparam logic [PHASE_W-1:0] PHASE_ONE = PHASE_W'(1);
  localparam logic [PHASE_W-1:0] PHASE_ZERO = PHASE_W'(0);

  logic               lock_s;
  clk_state_e         state_r, state_nxt_s;
  logic [15:0]        wait_cnt_r, wait_cnt_nxt_s;
  logic [PHASE_W-1:0] phase_r, phase_nxt_s;
  logic [3:0]         ecnt_r, ecnt_nxt_s;
  logic               run_nxt_s;
  logic               clk28_nxt_s, clk7_nxt_s, clk7n_nxt_s, cck_nxt_s, eclk_nxt_s;
  logic               core_reset_r, ready_r, clk28_r, clk7_r, clk7n_r, cck_r, eclk_r;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Lock FSM: loss of lock beats every other transition.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      HOLD: begin
        wait_cnt_nxt_s = 16'd0;
        if (lock_s) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      WAIT: begin
        if (!lock_s) begin
          state_nxt_s    = HOLD;
          wait_cnt_nxt_s = 16'd0;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = RUN;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 16'd1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s    = HOLD;
        wait_cnt_nxt_s = 16'd0;
      end
    endcase
  end

  // Phase and E counters plus the next values of every registered output.
  // Outputs are computed from next-state so they line up with phase/state.
  always_comb begin
    run_nxt_s  = (state_nxt_s == RUN);
    phase_nxt_s = PHASE_ZERO;
    ecnt_nxt_s  = 4'd0;
    if (run_nxt_s && (state_r == RUN)) begin
      phase_nxt_s = phase_r + PHASE_ONE;
    end else begin
      phase_nxt_s = PHASE_ZERO;
    end
    if (!run_nxt_s) begin
      ecnt_nxt_s = 4'd0;
    end else if (clk7_r) begin
      ecnt_nxt_s = ecnt_step(ecnt_r);
    end else begin
      ecnt_nxt_s = ecnt_r;
    end
    clk28_nxt_s = run_nxt_s && (phase_nxt_s[1:0] == 2'd3);
    clk7_nxt_s  = run_nxt_s && (phase_nxt_s[3:0] == 4'd15);
    clk7n_nxt_s = run_nxt_s && (phase_nxt_s[3:0] == 4'd7);
    cck_nxt_s   = run_nxt_s && phase_nxt_s[PHASE_W-1];
    eclk_nxt_s  = clk7_nxt_s && (ecnt_nxt_s == ECNT_LAST);
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= HOLD;
      wait_cnt_r   <= 16'd0;
      phase_r      <= PHASE_ZERO;
      ecnt_r       <= 4'd0;
      core_reset_r <= 1'b1;
      ready_r      <= 1'b0;
      clk28_r      <= 1'b0;
      clk7_r       <= 1'b0;
      clk7n_r      <= 1'b0;
      cck_r        <= 1'b0;
      eclk_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      wait_cnt_r   <= wait_cnt_nxt_s;
      phase_r      <= phase_nxt_s;
      ecnt_r       <= ecnt_nxt_s;
      core_reset_r <= !run_nxt_s;
      ready_r      <= run_nxt_s;
      clk28_r      <= clk28_nxt_s;
      clk7_r       <= clk7_nxt_s;
      clk7n_r      <= clk7n_nxt_s;
      cck_r        <= cck_nxt_s;
      eclk_r       <= eclk_nxt_s;
    end
  end

  assign core_reset = core_reset_r;
  assign ready      = ready_r;
  assign clk28_en   = clk28_r;
  assign clk7_en    = clk7_r;
  assign clk7n_en   = clk7n_r;
  assign cck        = cck_r;
  assign eclk_en    = eclk_r;
  assign phase      = phase_r;

endmodule

// File: tb/tb_amiga_clk_ctrl.sv
// Directed self-checking bench for amiga_clk_ctrl (LOCK_WAIT=16, SYNC_STAGES=2).
module tb_amiga_clk_ctrl;

  localparam int LW = 16;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       core_reset, ready, clk28_en, clk7_en, clk7n_en, cck, eclk_en;
  logic [4:0] phase;

  int n_checks = 0;
  int n_errors = 0;
  int en_in_reset = 0;
  int en_consec = 0;
  int ready_bad = 0;
  logic [3:0] prev_en = 4'd0;

  amiga_clk_ctrl #(.LOCK_WAIT(LW), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .core_reset (core_reset),
    .ready      (ready),
    .clk28_en   (clk28_en),
    .clk7_en    (clk7_en),
    .clk7n_en   (clk7n_en),
    .cck        (cck),
    .eclk_en    (eclk_en),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles_until_reset(input logic level, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (core_reset !== level && n < limit);
  endtask

  // Global monitors: no enable in reset, no enable twice in a row, ready == ~core_reset.
  always @(negedge clk) begin
    if (core_reset === 1'b1 && {clk28_en, clk7_en, clk7n_en, eclk_en} !== 4'd0)
      en_in_reset <= en_in_reset + 1;
    if ((({clk28_en, clk7_en, clk7n_en, eclk_en}) & prev_en) !== 4'd0)
      en_consec <= en_consec + 1;
    if (!rst && ready !== ~core_reset)
      ready_bad <= ready_bad + 1;
    prev_en <= {clk28_en, clk7_en, clk7n_en, eclk_en};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c28, c7, c7n, ce, tog, viol, last7, last7n, e_first, e_second;
    int ph, bad_rst, bad_en;
    logic prev_cck;
    logic [4:0] exp_phase;

    // Reset state
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (4) tick();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_ready", ready, 0);
    chk("rst_phase", phase, 0);
    chk("rst_enables", {clk28_en, clk7_en, clk7n_en, eclk_en, cck}, 0);

    // Lock release latency
    rst = 1'b0;
    pll_locked = 1'b1;
    cycles_until_reset(1'b0, 100, n);
    chk("lock_release_latency", n, SS + 1 + LW);
    chk("run_ready", ready, 1);
    chk("run_first_phase", phase, 0);

    // 320-cycle window from phase 0, plus one extra sample for cck toggles
    c28 = 0; c7 = 0; c7n = 0; ce = 0; tog = 0; viol = 0;
    last7 = -1; last7n = -1; e_first = -1; e_second = -1;
    prev_cck = cck;
    for (int i = 0; i <= 320; i++) begin
      if (i > 0) tick();
      ph = i % 32;
      exp_phase = 5'(ph);
      chk("win_phase", phase, exp_phase);
      chk("win_outputs", {clk28_en, clk7_en, clk7n_en, eclk_en, cck},
          {(ph % 4) == 3, (ph % 16) == 15, (ph % 16) == 7, (i == 159) || (i == 319), ph >= 16});
      if (i > 0 && cck !== prev_cck) tog++;
      prev_cck = cck;
      if (i < 320) begin
        if (clk28_en) c28++;
        if (clk7_en) c7++;
        if (clk7n_en) c7n++;
        if (eclk_en) begin
          ce++;
          if (e_first < 0) e_first = i; else e_second = i;
        end
        if (clk7_en && !clk28_en) viol++;
        if (clk7_en) begin
          if (last7n >= 0 && i - last7n != 8) viol++;
          last7 = i;
        end
        if (clk7n_en) begin
          if (last7 >= 0 && i - last7 != 8) viol++;
          last7n = i;
        end
      end
    end
    chk("cnt_clk28", c28, 80);
    chk("cnt_clk7", c7, 20);
    chk("cnt_clk7n", c7n, 20);
    chk("cnt_eclk", ce, 2);
    chk("cck_toggles", tog, 20);
    chk("phase_relation", viol, 0);
    chk("eclk_first", e_first, 159);
    chk("eclk_second", e_second, 319);

    // One-cycle lock glitch at phase 20
    n = 0;
    while (phase !== 5'd20 && n < 64) begin
      tick();
      n++;
    end
    chk("glitch_phase_found", phase, 20);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    cycles_until_reset(1'b1, 20, n);
    chk("glitch_reset_latency", n + 1, SS + 1);
    chk("glitch_enables_off", {clk28_en, clk7_en, clk7n_en, eclk_en, cck}, 0);
    chk("glitch_phase_zero", phase, 0);
    cycles_until_reset(1'b0, 100, n);
    chk("glitch_restart_window", n, LW + 1);
    chk("glitch_restart_phase", phase, 0);

    // Reset in RUN with lock held high
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("run_rst_core_reset", core_reset, 1);
    chk("run_rst_phase", phase, 0);
    chk("run_rst_enables", {clk28_en, clk7_en, clk7n_en, eclk_en, cck}, 0);

    // Reset in WAIT at wait count 10
    rst = 1'b0;
    repeat (SS + 1 + 10) tick();
    chk("midwait_in_wait", core_reset, 1);
    rst = 1'b1;
    tick();
    chk("midwait_rst_core_reset", core_reset, 1);
    chk("midwait_rst_ready", ready, 0);
    rst = 1'b0;
    cycles_until_reset(1'b0, 100, n);
    chk("midwait_full_window", n, SS + 1 + LW);

    // Never locked
    pll_locked = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad_rst = 0;
    bad_en = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (core_reset !== 1'b1) bad_rst++;
      if ({clk28_en, clk7_en, clk7n_en, eclk_en, cck} !== 5'd0) bad_en++;
    end
    chk("nolock_core_reset", bad_rst, 0);
    chk("nolock_enables", bad_en, 0);

    tick();
    chk("mon_enable_in_reset", en_in_reset, 0);
    chk("mon_enable_consecutive", en_consec, 0);
    chk("mon_ready_inverse", ready_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
